// File: rtl/ascon_serial_ctrl.sv
// Sequencer for the masked bit-serial Ascon decryption core: latches host operands,
// streams them MSB-first with LFSR masking, waits for the core and collects PT/tag.
module ascon_serial_ctrl #(
    parameter int          K          = 128,
    parameter int          L          = 40,
    parameter int          Y          = 80,
    parameter int          START_HOLD = 3,
    parameter int          GAP_CYC    = 2,
    parameter int          TIMEOUT    = 4096,
    parameter logic [31:0] SEED       = 32'hACE1_2024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [K-1:0] key,
    input  logic [127:0] nonce,
    input  logic [L-1:0] ad,
    input  logic [Y-1:0] ct,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [Y-1:0] pt,
    output logic [127:0] tag,
    output logic         err,
    output logic [15:0]  latency,
    output logic         core_rst,
    output logic [2:0]   keyxSO,
    output logic [2:0]   noncexSO,
    output logic [2:0]   associated_dataxSO,
    output logic [2:0]   cipher_textxSO,
    output logic [6:0]   r_64xSO,
    output logic         r_128xSO,
    output logic         r_ptxSO,
    output logic         decryption_startxSO,
    input  logic         plain_textxSI,
    input  logic         tagxSI,
    input  logic         decryption_readyxSI
);
    localparam int MAX_KY  = (K > Y) ? K : Y;
    localparam int MAX_KYL = (MAX_KY > L) ? MAX_KY : L;
    localparam int MAX     = (MAX_KYL > 128) ? MAX_KYL : 128;

    localparam logic [15:0] LAST_LOAD  = 16'(MAX - 1);
    localparam logic [15:0] LAST_START = 16'(START_HOLD - 1);
    localparam logic [15:0] LAST_WAIT  = 16'(TIMEOUT - 1);
    localparam logic [15:0] LAST_GAP   = 16'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4,
        S_READ  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        if (s[0]) begin
            return (s >> 1) ^ 32'h8020_0003;
        end else begin
            return s >> 1;
        end
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    state_t         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [K-1:0]   key_q, key_d;
    logic [127:0]   nonce_q, nonce_d;
    logic [L-1:0]   ad_q, ad_d;
    logic [Y-1:0]   ct_q, ct_d;
    logic           sticky_q, sticky_d;
    logic [15:0]    lat_q, lat_d;
    logic [Y-1:0]   pt_q, pt_d;
    logic [127:0]   tag_q, tag_d;
    logic           err_q, err_d;
    logic           core_rst_q, core_rst_d;
    logic [31:0]    lfsr_q, lfsr_d;
    logic [16:0]    rnd_q, rnd_d;
    logic [3:0]     dbit_q, dbit_d;
    logic           start_q, start_d;
    logic           req_ready_q, req_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [K-1:0]   key_sh_s;
    logic [127:0]   nonce_sh_s;
    logic [L-1:0]   ad_sh_s;
    logic [Y-1:0]   ct_sh_s;
    logic           active_d_s;

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_d      = key_q;
        nonce_d    = nonce_q;
        ad_d       = ad_q;
        ct_d       = ct_q;
        sticky_d   = sticky_q;
        lat_d      = lat_q;
        pt_d       = pt_q;
        tag_d      = tag_q;
        err_d      = err_q;
        core_rst_d = 1'b0;

        if (state_q != S_IDLE && state_q != S_DONE) begin
            lfsr_d = lfsr_step(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    key_d    = key;
                    nonce_d  = nonce;
                    ad_d     = ad;
                    ct_d     = ct;
                    cnt_d    = 16'd0;
                    sticky_d = 1'b0;
                    lat_d    = 16'd0;
                    pt_d     = '0;
                    tag_d    = '0;
                    err_d    = 1'b0;
                    state_d  = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (cnt_q == LAST_LOAD) begin
                    cnt_d   = 16'd0;
                    lat_d   = 16'd0;
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_START: begin
                lat_d = sat_inc(lat_q);
                // A ready seen while start is still high must not be lost.
                if (decryption_readyxSI) begin
                    sticky_d = 1'b1;
                end else begin
                    sticky_d = sticky_q;
                end
                if (cnt_q == LAST_START) begin
                    cnt_d   = 16'd0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT: begin
                if (decryption_readyxSI || sticky_q) begin
                    cnt_d   = 16'd0;
                    state_d = S_GAP;
                end else if (cnt_q == LAST_WAIT) begin
                    err_d      = 1'b1;
                    core_rst_d = 1'b1;
                    cnt_d      = 16'd0;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    lat_d = sat_inc(lat_q);
                end
            end
            S_GAP: begin
                if (cnt_q == LAST_GAP) begin
                    cnt_d   = 16'd0;
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_READ: begin
                // Results arrive LSB-first; indices beyond a field's width shift out to nothing.
                pt_d  = pt_q | ({{(Y-1){1'b0}}, plain_textxSI} << cnt_q);
                tag_d = tag_q | ({127'd0, tagxSI} << cnt_q);
                if (cnt_q == LAST_LOAD) begin
                    cnt_d   = 16'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        endcase

        active_d_s = (state_d != S_IDLE) && (state_d != S_DONE);
        if (active_d_s) begin
            rnd_d = lfsr_d[16:0];
        end else begin
            rnd_d = 17'd0;
        end

        // MSB-first streaming; a shift past the width yields the required zero.
        key_sh_s   = key_d << cnt_d;
        nonce_sh_s = nonce_d << cnt_d;
        ad_sh_s    = ad_d << cnt_d;
        ct_sh_s    = ct_d << cnt_d;
        if (state_d == S_LOAD) begin
            dbit_d = {key_sh_s[K-1], nonce_sh_s[127], ad_sh_s[L-1], ct_sh_s[Y-1]};
        end else begin
            dbit_d = 4'd0;
        end

        start_d     = (state_d == S_START);
        req_ready_d = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // All state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            key_q       <= '0;
            nonce_q     <= 128'd0;
            ad_q        <= '0;
            ct_q        <= '0;
            sticky_q    <= 1'b0;
            lat_q       <= 16'd0;
            pt_q        <= '0;
            tag_q       <= 128'd0;
            err_q       <= 1'b0;
            core_rst_q  <= 1'b1;
            lfsr_q      <= SEED;
            rnd_q       <= 17'd0;
            dbit_q      <= 4'd0;
            start_q     <= 1'b0;
            req_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            nonce_q     <= nonce_d;
            ad_q        <= ad_d;
            ct_q        <= ct_d;
            sticky_q    <= sticky_d;
            lat_q       <= lat_d;
            pt_q        <= pt_d;
            tag_q       <= tag_d;
            err_q       <= err_d;
            core_rst_q  <= core_rst_d;
            lfsr_q      <= lfsr_d;
            rnd_q       <= rnd_d;
            dbit_q      <= dbit_d;
            start_q     <= start_d;
            req_ready_q <= req_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign req_ready           = req_ready_q;
    assign out_valid           = out_valid_q;
    assign pt                  = pt_q;
    assign tag                 = tag_q;
    assign err                 = err_q;
    assign latency             = lat_q;
    assign core_rst            = core_rst_q;
    assign decryption_startxSO = start_q;
    assign r_128xSO            = rnd_q[16];
    assign r_ptxSO             = rnd_q[15];
    assign r_64xSO             = rnd_q[14:8];
    assign keyxSO              = {rnd_q[7:6], dbit_q[3]};
    assign associated_dataxSO  = {rnd_q[5:4], dbit_q[1]};
    assign cipher_textxSO      = {rnd_q[3:2], dbit_q[0]};
    assign noncexSO            = {rnd_q[1:0], dbit_q[2]};

endmodule

// File: tb/tb_ascon_serial_ctrl.sv
// Randomized self-checking bench for ascon_serial_ctrl with a cycle-accurate core stub.
module tb_ascon_serial_ctrl;
    localparam int K = 128, L = 40, Y = 80, MAX = 128;
    localparam int START_HOLD = 3, GAP_CYC = 2, TIMEOUT = 4096;
    localparam logic [31:0] SEED = 32'hACE1_2024;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, out_valid, out_ready, err, core_rst;
    logic [K-1:0] key;
    logic [127:0] nonce, tag;
    logic [L-1:0] ad;
    logic [Y-1:0] ct, pt;
    logic [15:0]  latency;
    logic [2:0]   keyxSO, noncexSO, associated_dataxSO, cipher_textxSO;
    logic [6:0]   r_64xSO;
    logic         r_128xSO, r_ptxSO, decryption_startxSO;
    logic         plain_textxSI, tagxSI, decryption_readyxSI;

    int total = 0;
    int bad   = 0;

    logic [Y-1:0]  r_pt;
    logic [127:0]  r_tag;
    logic [15:0]   r_lat;
    logic          r_err;
    logic          r_done;

    always #5 clk = ~clk;

    ascon_serial_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .key(key), .nonce(nonce), .ad(ad), .ct(ct),
        .out_valid(out_valid), .out_ready(out_ready), .pt(pt), .tag(tag),
        .err(err), .latency(latency), .core_rst(core_rst),
        .keyxSO(keyxSO), .noncexSO(noncexSO), .associated_dataxSO(associated_dataxSO),
        .cipher_textxSO(cipher_textxSO), .r_64xSO(r_64xSO), .r_128xSO(r_128xSO),
        .r_ptxSO(r_ptxSO), .decryption_startxSO(decryption_startxSO),
        .plain_textxSI(plain_textxSI), .tagxSI(tagxSI), .decryption_readyxSI(decryption_readyxSI)
    );

    function automatic logic [31:0] lfsr_model(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_ops;
        key   = {$urandom, $urandom, $urandom, $urandom};
        nonce = {$urandom, $urandom, $urandom, $urandom};
        ad    = {8'($urandom), $urandom};
        ct    = {16'($urandom), $urandom, $urandom};
    endtask

    // One transaction driven through a behavioural core stub; ready_at < 0 means never ready.
    task automatic run_req(input logic [K-1:0] k, input logic [127:0] n, input logic [L-1:0] a,
                           input logic [Y-1:0] c, input int ready_at, input bit ready_pulse,
                           input logic [Y-1:0] pt_src, input logic [127:0] tag_src,
                           input bit check_rnd, input bit busy_poke, input int abort_at);
        logic [31:0] lm;
        logic [3:0]  exp_b, got_b;
        logic [16:0] got_r;
        int d;
        r_done = 1'b0;
        for (int w = 0; w < 8 && req_ready !== 1'b1; w++) tick();
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL req_ready_wait: got %b want 1", req_ready);
        end
        key = k; nonce = n; ad = a; ct = c; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        scramble_ops();
        lm = SEED;
        for (int i = 0; i < MAX; i++) begin
            exp_b = {k[K-1-i], n[127-i], (i < Y) ? c[Y-1-i] : 1'b0, (i < L) ? a[L-1-i] : 1'b0};
            got_b = {keyxSO[0], noncexSO[0], cipher_textxSO[0], associated_dataxSO[0]};
            total++;
            if (got_b !== exp_b || decryption_startxSO !== 1'b0) begin
                bad++;
                $display("FAIL load_bits i=%0d: got k/n/c/a=%b start=%b want %b start=0", i, got_b, decryption_startxSO, exp_b);
            end
            if (check_rnd) begin
                got_r = {r_128xSO, r_ptxSO, r_64xSO, keyxSO[2:1], associated_dataxSO[2:1],
                         cipher_textxSO[2:1], noncexSO[2:1]};
                total++;
                if (got_r !== lm[16:0]) begin
                    bad++;
                    $display("FAIL lfsr_bits i=%0d: got %h want %h", i, got_r, lm[16:0]);
                end
                lm = lfsr_model(lm);
            end
            tick();
        end
        for (int t = 0; t < START_HOLD; t++) begin
            decryption_readyxSI = (ready_at >= 0) && (ready_pulse ? (t == ready_at) : (t >= ready_at));
            total++;
            if (decryption_startxSO !== 1'b1) begin
                bad++;
                $display("FAIL start_high t=%0d: got %b want 1", t, decryption_startxSO);
            end
            tick();
        end
        total++;
        if (decryption_startxSO !== 1'b0) begin
            bad++;
            $display("FAIL start_low: got %b want 0", decryption_startxSO);
        end
        if (ready_at < 0) begin
            for (int t = START_HOLD; t < START_HOLD + TIMEOUT; t++) begin
                decryption_readyxSI = 1'b0;
                if (t == START_HOLD + TIMEOUT - 1) begin
                    total++;
                    if (out_valid !== 1'b0 || core_rst !== 1'b0) begin
                        bad++;
                        $display("FAIL timeout_early: got out_valid=%b core_rst=%b want 0/0", out_valid, core_rst);
                    end
                end
                tick();
            end
        end else begin
            d = (ready_at < START_HOLD) ? START_HOLD : ready_at;
            for (int t = START_HOLD; t <= d; t++) begin
                decryption_readyxSI = ready_pulse ? (t == ready_at) : (t >= ready_at);
                if (busy_poke && t == START_HOLD + 1) begin
                    scramble_ops();
                    req_valid = 1'b1;
                    total++;
                    if (req_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL busy_ready: got %b want 0", req_ready);
                    end
                end else begin
                    req_valid = 1'b0;
                end
                tick();
            end
            req_valid = 1'b0;
            decryption_readyxSI = 1'b0;
            for (int g = 0; g < GAP_CYC; g++) tick();
            for (int i = 0; i < MAX; i++) begin
                plain_textxSI = (i < Y) ? pt_src[i] : 1'($urandom);
                tagxSI = tag_src[i];
                if (i == abort_at) begin
                    rst = 1'b1;
                    #1;
                    total++;
                    if (req_ready !== 1'b1 || out_valid !== 1'b0 || core_rst !== 1'b1 || pt !== '0 ||
                        tag !== '0 || latency !== 16'd0 || err !== 1'b0 || decryption_startxSO !== 1'b0 ||
                        {keyxSO, noncexSO, associated_dataxSO, cipher_textxSO, r_64xSO, r_128xSO, r_ptxSO} !== '0) begin
                        bad++;
                        $display("FAIL abort_reset: got rdy=%b ov=%b crst=%b pt=%h lat=%0d", req_ready, out_valid, core_rst, pt, latency);
                    end
                    tick();
                    rst = 1'b0;
                    tick();
                    return;
                end
                tick();
            end
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL done_timing: got out_valid=%b want 1", out_valid);
        end
        r_pt = pt; r_tag = tag; r_lat = latency; r_err = err; r_done = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (req_ready !== 1'b1 || out_valid !== 1'b0 || core_rst !== 1'b1 || decryption_startxSO !== 1'b0 ||
                {keyxSO, noncexSO, associated_dataxSO, cipher_textxSO, r_64xSO, r_128xSO, r_ptxSO} !== '0 ||
                pt !== '0 || tag !== '0 || latency !== 16'd0 || err !== 1'b0) begin
                bad++;
                $display("FAIL reset_state: got rdy=%b ov=%b crst=%b key_so=%b", req_ready, out_valid, core_rst, keyxSO);
            end
        end
        rst = 1'b0;
        tick();
        total++;
        if (core_rst !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got core_rst=%b req_ready=%b want 0/1", core_rst, req_ready);
        end
    endtask

    task automatic test_vector;
        logic [Y-1:0]  pv;
        logic [127:0]  tv;
        pv = 80'hA5A5_A5A5_A5A5_A5A5_A5A5;
        tv = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        total++;
        if (1'b1) begin end
        total--;
        run_req(128'h2db083053e848cefa30007336c47a5a1, 128'h3f3607dbce3503ba84f5843d623de056,
                40'h4153434f4e, 80'h87a59a2ea49b233259e3, 20, 1'b0, pv, tv, 1'b1, 1'b0, -1);
        total++;
        if (r_pt !== pv || r_tag !== tv || r_lat !== 16'd20 || r_err !== 1'b0) begin
            bad++;
            $display("FAIL vector_result: got pt=%h tag=%h lat=%0d err=%b want pt=%h tag=%h lat=20 err=0", r_pt, r_tag, r_lat, r_err, pv, tv);
        end
        out_ready = 1'b0;
        for (int h = 0; h < 10; h++) begin
            total++;
            if (out_valid !== 1'b1 || pt !== pv || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL done_hold h=%0d: got out_valid=%b req_ready=%b", h, out_valid, req_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL release: got out_valid=%b req_ready=%b err=%b want 0/1/0", out_valid, req_ready, err);
        end
    endtask

    task automatic test_random;
        logic [Y-1:0]  pv;
        logic [127:0]  tv;
        int ra;
        for (int it = 0; it < 3; it++) begin
            pv = {16'($urandom), $urandom, $urandom};
            tv = {$urandom, $urandom, $urandom, $urandom};
            ra = int'($urandom_range(3, 40));
            run_req({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                    {8'($urandom), $urandom}, {16'($urandom), $urandom, $urandom},
                    ra, 1'b0, pv, tv, 1'b0, 1'b0, -1);
            total++;
            if (r_pt !== pv || r_tag !== tv || r_lat !== 16'(ra) || r_err !== 1'b0) begin
                bad++;
                $display("FAIL random_result it=%0d: got pt=%h lat=%0d want pt=%h lat=%0d", it, r_pt, r_lat, pv, ra);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_sticky;
        logic [Y-1:0]  pv;
        logic [127:0]  tv;
        pv = {16'($urandom), $urandom, $urandom};
        tv = {$urandom, $urandom, $urandom, $urandom};
        run_req('1, '0, '1, '0, 2, 1'b1, pv, tv, 1'b0, 1'b0, -1);
        total++;
        if (r_pt !== pv || r_tag !== tv || r_lat !== 16'd3) begin
            bad++;
            $display("FAIL sticky_result: got pt=%h lat=%0d want pt=%h lat=3", r_pt, r_lat, pv);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_timeout;
        run_req({$urandom, $urandom, $urandom, $urandom}, '0, '0, '0, -1, 1'b0, '1, '1, 1'b0, 1'b0, -1);
        total++;
        if (r_err !== 1'b1 || core_rst !== 1'b1 || r_pt !== '0 || r_tag !== '0) begin
            bad++;
            $display("FAIL timeout_done: got err=%b core_rst=%b pt=%h want 1/1/0", r_err, core_rst, r_pt);
        end
        tick();
        total++;
        if (core_rst !== 1'b0 || out_valid !== 1'b1 || err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_pulse: got core_rst=%b out_valid=%b err=%b want 0/1/1", core_rst, out_valid, err);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (err !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear: got err=%b out_valid=%b want 0/0", err, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [Y-1:0]  pv;
        logic [127:0]  tv;
        int ra;
        run_req({$urandom, $urandom, $urandom, $urandom}, '0, '0, '0, 25, 1'b0, '1, '1, 1'b0, 1'b0, 50);
        total++;
        if (r_done !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_result: got out_valid=%b want 0", out_valid);
        end
        pv = {16'($urandom), $urandom, $urandom};
        tv = {$urandom, $urandom, $urandom, $urandom};
        ra = int'($urandom_range(10, 30));
        run_req({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                {8'($urandom), $urandom}, {16'($urandom), $urandom, $urandom},
                ra, 1'b0, pv, tv, 1'b1, 1'b1, -1);
        total++;
        if (r_pt !== pv || r_tag !== tv || r_lat !== 16'(ra) || r_err !== 1'b0) begin
            bad++;
            $display("FAIL recover_result: got pt=%h lat=%0d want pt=%h lat=%0d", r_pt, r_lat, pv, ra);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; out_ready = 1'b0;
        key = '0; nonce = '0; ad = '0; ct = '0;
        plain_textxSI = 1'b0; tagxSI = 1'b0; decryption_readyxSI = 1'b0;
        test_reset();
        test_vector();
        test_random();
        test_sticky();
        test_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ascon_serial_ctrl.md
Name: ascon_serial_ctrl

Overview:
Sequencer for the bit-serial Ascon decryption core (Ascon, masked serial interface). It takes parallel key/nonce/AD/CT from a host with a valid/ready handshake. It then shifts the operands into the core MSB-first, filling the random share/mask lines from an internal LFSR, and pulses decryption_start. Once the core raises decryption_ready, it shifts plaintext and tag back out and presents them in parallel with the measured latency.

Parameters:
K, 128, key width (bits)
L, 40, associated-data width
Y, 80, plaintext/ciphertext width
MAX, max(K,Y,L,128), serial transfer length in cycles (derived, not overridden)
START_HOLD, 3, cycles decryption_start is held high
GAP_CYC, 2, cycles between ready detection and first read sample
TIMEOUT, 4096, maximum cycles waited for ready
SEED, 32'hACE1_2024, LFSR reset value (must be nonzero)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  host request valid
req_ready  out  1  controller idle, request accepted when valid&&ready
key  in  K  decryption key
nonce  in  128  nonce
ad  in  L  associated data
ct  in  Y  ciphertext
out_valid  out  1  result valid, held until out_ready
out_ready  in  1  host accepts result
pt  out  Y  recovered plaintext
tag  out  128  recovered tag
err  out  1  timeout occurred (valid with out_valid)
latency  out  16  cycles from first START cycle to ready detection
core_rst  out  1  reset to the core
keyxSO, noncexSO, associated_dataxSO, cipher_textxSO  out  3 each  bit0 = data bit, bits[2:1] = LFSR randomness
r_64xSO  out  7  randomness
r_128xSO, r_ptxSO  out  1 each  randomness
decryption_startxSO  out  1  core start
plain_textxSI, tagxSI, decryption_readyxSI  in  1 each  core serial outputs / done

Behaviour:
- Reset (async, rst=1): state IDLE, req_ready=1, out_valid=0, err=0, latency=0, pt=0, tag=0, decryption_startxSO=0, core_rst=1. All serial outputs are 0. LFSR=SEED, counter=0.
- All outputs are registered.
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1, advances every cycle in every state except IDLE/DONE. Its low 17 bits drive {r_128, r_pt, r_64[6:0], key[2:1], ad[2:1], ct[2:1], nonce[2:1]} in that MSB-to-LSB order.
- IDLE: req_ready=1. On req_valid&&req_ready, latch the operands, set req_ready=0, counter i=0, go to LOAD.
- LOAD (MAX cycles): in cycle i, bit0 lines carry key[K-1-i], nonce[127-i], ct[Y-1-i], ad[L-1-i]. An index below 0 drives 0. After i=MAX-1, go to START. bit0 lines are 0 outside LOAD.
- START (START_HOLD cycles): decryption_startxSO=1. The latency counter starts at 0 in the first START cycle. decryption_readyxSI seen high here is remembered (sticky).
- WAIT: start=0; latency increments each cycle. On the first cycle ready=1 is sampled (or the sticky flag is set on entry), latency is frozen and the FSM goes to GAP.
- Timeout: if the WAIT count reaches TIMEOUT, set err=1, pulse core_rst for 1 cycle, leave pt and tag at 0, and go to DONE.
- GAP (GAP_CYC cycles): idle.
- READ (MAX cycles): in cycle i, pt[i]<=plain_textxSI if i<Y, and tag[i]<=tagxSI if i<128. Then go to DONE.
- DONE: out_valid=1, outputs stable. On out_ready, clear out_valid and err and go to IDLE (req_ready=1 the next cycle). A new request cannot be accepted in the same cycle.
- Latency saturates at 16'hFFFF.
- Reset mid-operation aborts immediately and returns all outputs to reset values. No partial result is presented.
- req_valid while busy is ignored; the operands are not re-latched.
- The host operand inputs may change after acceptance without affecting the transfer.

Test Plan:
- Reset hold 3 cycles -> req_ready=1, out_valid=0, core_rst=1, all serial outputs 0; after release core_rst=0 and the LFSR low bits equal SEED[16:0] on the first LOAD cycle.
- Request with KEY=2db083053e848cefa30007336c47a5a1, NONCE=3f3607dbce3503ba84f5843d623de056, AD=4153434f4e, CT=87a59a2ea49b233259e3:
  - LOAD i=0: key/nonce/ct/ad bit0 = 0/0/1/0.
  - LOAD i=1: 0/0/0/1.
  - ad bit0=0 for i>=40 and ct bit0=0 for i>=80; LOAD lasts exactly 128 cycles; start high exactly 3 cycles.
- Behavioural core stub asserts ready 20 cycles after the first START cycle and drives pt bits from 80'hA5... and tag bits from 128'h0123... LSB-first -> pt and tag match the stub values, latency=20, err=0, out_valid held with out_ready=0 for 10 cycles, then drops 1 cycle after out_ready.
- Stub never asserts ready -> after 4096 WAIT cycles: err=1, core_rst pulses 1 cycle, out_valid=1, pt=0.
- Ready asserted during START cycle 2 -> sticky flag is taken; GAP is entered on the first WAIT cycle; latency=3.
- rst asserted at READ cycle 50 -> outputs reset asynchronously; the next request completes normally. A req_valid pulse during WAIT is ignored.
